// File: rtl/game_round_ctrl.sv
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Frame-clocked game sequencer. It runs the menu, a pre-round
//            countdown, NUM_ROUNDS timed rounds and an end screen. It also
//            gates obstacle spawning, drives the round-progress LED bar, and
//            reports the round index and phase.
//            Optional pause support is enabled by defining GAME_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_round_ctrl #(
    parameter int ROUND_FRAMES     = 7142,
    parameter int COUNTDOWN_FRAMES = 179,
    parameter int NUM_ROUNDS       = 3,
    parameter int LED_W            = 10,
    parameter int TIMER_W          = 16
) (
    input  logic               FrameClk,
    input  logic               Reset_n,
    input  logic               Continue,
    input  logic               Pause,
    output logic               SpawnEnable,
    output logic [2:0]         Phase,
    output logic [3:0]         Round,
    output logic [TIMER_W-1:0] Timer,
    output logic               RoundDone,
    output logic               GameOver,
    output logic [LED_W-1:0]   LED
);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_ROUND_END = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    // LED progress is floor(LED_W*Timer/ROUND_FRAMES). It is tracked as a
    // quotient/remainder pair that advances by LED_W per frame, so no divider
    // is needed.
    localparam int c_LIT_W = $clog2(LED_W + 1);
    localparam int c_ACC_W = $clog2(2 * ROUND_FRAMES) + 1;

    localparam logic [c_LIT_W-1:0] c_LED_Q   = c_LIT_W'(LED_W / ROUND_FRAMES);
    localparam logic [c_ACC_W-1:0] c_LED_R   = c_ACC_W'(LED_W % ROUND_FRAMES);
    localparam logic [c_ACC_W-1:0] c_RF      = c_ACC_W'(ROUND_FRAMES);
    localparam logic [LED_W-1:0]   c_LED_ALL = '1;

    localparam logic [TIMER_W-1:0] c_ROUND_LAST = TIMER_W'(ROUND_FRAMES - 1);
    localparam logic [TIMER_W-1:0] c_CD_LAST    = TIMER_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [3:0]         c_LAST_ROUND = 4'(NUM_ROUNDS - 1);

    // A round starts with the countdown unless the countdown length is zero.
    localparam state_t c_START = (COUNTDOWN_FRAMES == 0) ? S_PLAY : S_COUNTDOWN;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_round, w_round_nxt;
    logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
    logic [c_LIT_W-1:0]   r_lit, w_lit_nxt;
    logic [c_ACC_W-1:0]   r_acc, w_acc_nxt;
    logic                 r_round_done, w_round_done_nxt;
    logic                 r_game_over, w_game_over_nxt;
    logic                 r_spawn;
    logic [LED_W-1:0]     r_led, w_led_nxt;

    logic                 r_cont_q;
    logic                 r_armed;
    logic                 w_cont_rise;
    logic                 w_pause_rise;
    logic [c_ACC_W-1:0]   w_acc_sum;
    logic [c_LIT_W-1:0]   w_step_lit;
    logic [c_ACC_W-1:0]   w_step_acc;

    // The armed flag masks the first frame after reset. Because of it, a
    // button held through reset release does not count as a press.
    always_ff @(posedge FrameClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cont_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_cont_q <= Continue;
            r_armed  <= 1'b1;
        end
    end

    assign w_cont_rise = Continue & ~r_cont_q & r_armed;

`ifdef GAME_PAUSE_EN
    logic r_pause_q;

    // Pause edge detector, with the same post-reset masking as Continue.
    always_ff @(posedge FrameClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pause_q <= 1'b0;
        end else begin
            r_pause_q <= Pause;
        end
    end

    assign w_pause_rise = Pause & ~r_pause_q & r_armed;
`else
    logic w_unused_pause;
    assign w_unused_pause = Pause;
    assign w_pause_rise   = 1'b0;
`endif

    // One-frame advance of the LED progress quotient/remainder pair.
    assign w_acc_sum  = r_acc + c_LED_R;
    assign w_step_acc = (w_acc_sum >= c_RF) ? (w_acc_sum - c_RF) : w_acc_sum;
    assign w_step_lit = (w_acc_sum >= c_RF) ? (r_lit + c_LED_Q + c_LIT_W'(1))
                                            : (r_lit + c_LED_Q);

    // Next-state, counter and pulse logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_round_nxt      = r_round;
        w_timer_nxt      = r_timer;
        w_lit_nxt        = r_lit;
        w_acc_nxt        = r_acc;
        w_round_done_nxt = 1'b0;
        w_game_over_nxt  = 1'b0;
        case (r_state)
            S_MENU: begin
                if (w_cont_rise) begin
                    w_state_nxt = c_START;
                    w_round_nxt = 4'd0;
                    w_timer_nxt = '0;
                    w_lit_nxt   = '0;
                    w_acc_nxt   = '0;
                end
            end
            S_COUNTDOWN: begin
                if (r_timer == c_CD_LAST) begin
                    w_state_nxt = S_PLAY;
                    w_timer_nxt = '0;
                    w_lit_nxt   = '0;
                    w_acc_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            S_PLAY: begin
                // The round-end check comes first, so a pause press on the
                // terminal frame is ignored.
                if (r_timer == c_ROUND_LAST) begin
                    w_round_done_nxt = 1'b1;
                    w_timer_nxt      = '0;
                    w_lit_nxt        = '0;
                    w_acc_nxt        = '0;
                    if (r_round == c_LAST_ROUND) begin
                        w_state_nxt     = S_GAME_OVER;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ROUND_END;
                    end
                end else if (w_pause_rise) begin
                    w_state_nxt = S_PAUSED;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                    w_lit_nxt   = w_step_lit;
                    w_acc_nxt   = w_step_acc;
                end
            end
            S_PAUSED: begin
                if (w_pause_rise) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_ROUND_END: begin
                if (w_cont_rise) begin
                    w_state_nxt = c_START;
                    w_round_nxt = r_round + 4'd1;
                    w_timer_nxt = '0;
                end
            end
            S_GAME_OVER: begin
                if (w_cont_rise) begin
                    w_state_nxt = c_START;
                    w_round_nxt = 4'd0;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_MENU;
                w_round_nxt = 4'd0;
                w_timer_nxt = '0;
                w_lit_nxt   = '0;
                w_acc_nxt   = '0;
            end
        endcase
    end

    // LED bar value for the phase being entered.
    always_comb begin
        w_led_nxt = '0;
        case (w_state_nxt)
            S_MENU, S_COUNTDOWN: w_led_nxt = c_LED_ALL;
            S_PLAY, S_PAUSED:    w_led_nxt = c_LED_ALL << w_lit_nxt;
            default:             w_led_nxt = '0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge FrameClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_MENU;
            r_round      <= 4'd0;
            r_timer      <= '0;
            r_lit        <= '0;
            r_acc        <= '0;
            r_round_done <= 1'b0;
            r_game_over  <= 1'b0;
            r_spawn      <= 1'b0;
            r_led        <= c_LED_ALL;
        end else begin
            r_state      <= w_state_nxt;
            r_round      <= w_round_nxt;
            r_timer      <= w_timer_nxt;
            r_lit        <= w_lit_nxt;
            r_acc        <= w_acc_nxt;
            r_round_done <= w_round_done_nxt;
            r_game_over  <= w_game_over_nxt;
            r_spawn      <= (w_state_nxt == S_PLAY);
            r_led        <= w_led_nxt;
        end
    end

    assign Phase       = r_state;
    assign Round       = r_round;
    assign Timer       = r_timer;
    assign SpawnEnable = r_spawn;
    assign RoundDone   = r_round_done;
    assign GameOver    = r_game_over;
    assign LED         = r_led;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// ============================================================================
// Module   : tb_game_round_ctrl
// Purpose  : Directed, self-checking bench for game_round_ctrl, using short
//            test parameters (10-frame rounds, 3-frame countdown, 2 rounds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cont;
    logic        pause;
    logic        spawn;
    logic [2:0]  phase;
    logic [3:0]  round;
    logic [15:0] timer;
    logic        round_done;
    logic        game_over;
    logic [9:0]  led;

    int n_checks = 0;
    int n_errors = 0;

    game_round_ctrl #(
        .ROUND_FRAMES     (10),
        .COUNTDOWN_FRAMES (3),
        .NUM_ROUNDS       (2),
        .LED_W            (10),
        .TIMER_W          (16)
    ) u_dut (
        .FrameClk    (clk),
        .Reset_n     (rst_n),
        .Continue    (cont),
        .Pause       (pause),
        .SpawnEnable (spawn),
        .Phase       (phase),
        .Round       (round),
        .Timer       (timer),
        .RoundDone   (round_done),
        .GameOver    (game_over),
        .LED         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One frame: wait for the edge, then settle before sampling or driving.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [9:0] ones;
        ones  = 10'h3FF;
        rst_n = 1'b0;
        cont  = 1'b1;
        pause = 1'b0;
        #2;
        step(2);
        check("rst_phase", phase, 0);
        check("rst_round", round, 0);
        check("rst_timer", timer, 0);
        check("rst_spawn", spawn, 0);
        check("rst_led", led, 10'h3FF);
        check("rst_rdone", round_done, 0);
        check("rst_gover", game_over, 0);

        // Continue is held through reset release, so it must not act as a press.
        rst_n = 1'b1;
        step(3);
        check("held_rst_phase", phase, 0);
        cont = 1'b0;
        step(1);

        // A Continue rise in MENU starts a 3-frame countdown and then PLAY.
        cont = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("cd_phase", phase, 1);
            check("cd_timer", timer, i);
            check("cd_led", led, 10'h3FF);
            step(1);
        end
        check("play_phase", phase, 2);
        check("play_spawn", spawn, 1);

        // Round 0: 10 PLAY frames, the LED bar shrinks by one bit per frame,
        // and Continue stays held high throughout.
        for (int i = 0; i < 10; i++) begin
            check("r0_phase", phase, 2);
            check("r0_timer", timer, i);
            check("r0_led", led, (ones << i) & 10'h3FF);
            check("r0_rdone", round_done, 0);
            if (i == 5) check("r0_led_t5", led, 10'h3E0);
            step(1);
        end
        check("r0_end_phase", phase, 4);
        check("r0_end_rdone", round_done, 1);
        check("r0_end_gover", game_over, 0);
        check("r0_end_led", led, 0);
        check("r0_end_spawn", spawn, 0);
        step(1);
        check("r0_rdone_pulse", round_done, 0);
        check("held_cont_phase", phase, 4);

        // Round 1, the last round, ends the game.
        cont = 1'b0;
        step(1);
        cont = 1'b1;
        step(1);
        check("r1_cd_phase", phase, 1);
        check("r1_round", round, 1);
        step(3);
        check("r1_play_phase", phase, 2);
        step(10);
        check("r1_end_phase", phase, 5);
        check("r1_end_rdone", round_done, 1);
        check("r1_end_gover", game_over, 1);
        check("r1_end_led", led, 0);
        step(1);
        check("gover_pulse", game_over, 0);
        cont = 1'b0;
        step(1);
        cont = 1'b1;
        step(1);
        check("restart_phase", phase, 1);
        check("restart_round", round, 0);
        step(3);
        check("g2_play_phase", phase, 2);
        check("g2_play_timer", timer, 0);

`ifdef GAME_PAUSE_EN
        step(4);
        check("pz_timer_pre", timer, 4);
        pause = 1'b1;
        step(1);
        check("pz_phase", phase, 3);
        check("pz_spawn", spawn, 0);
        check("pz_led", led, 10'h3F0);
        for (int i = 0; i < 20; i++) begin
            // A Continue press while paused is ignored.
            cont = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
            check("pz_hold_timer", timer, 4);
            check("pz_hold_phase", phase, 3);
        end
        pause = 1'b0;
        step(1);
        pause = 1'b1;
        step(1);
        check("resume_phase", phase, 2);
        check("resume_timer", timer, 4);
        step(5);
        check("resume_t9_phase", phase, 2);
        check("resume_t9_timer", timer, 9);
        step(1);
        check("pz_end_phase", phase, 4);
        check("pz_end_rdone", round_done, 1);
`else
        for (int i = 0; i < 10; i++) begin
            check("nopz_phase", phase, 2);
            check("nopz_timer", timer, i);
            pause = ~pause;
            step(1);
        end
        check("nopz_end_phase", phase, 4);
        check("nopz_end_rdone", round_done, 1);
`endif

        // Reset asserted mid-PLAY takes effect immediately, without waiting for a clock edge.
        cont  = 1'b0;
        pause = 1'b0;
        step(1);
        cont = 1'b1;
        step(1);
        step(3);
        step(2);
        check("pre_rst_phase", phase, 2);
        check("pre_rst_round", round, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_phase", phase, 0);
        check("async_rst_spawn", spawn, 0);
        check("async_rst_led", led, 10'h3FF);
        check("async_rst_round", round, 0);
        check("async_rst_rdone", round_done, 0);
        check("async_rst_gover", game_over, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_phase", phase, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
